// File: rtl/booth_seq_mul_ctrl.sv
// Sequential radix-2 Booth multiplier that performs one recoding step per clock.
// One shared adder/subtractor serves all WIDTH partial products. Handshake: start/busy/done.
module booth_seq_mul_ctrl #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Z
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               r_state;
  logic [WIDTH:0]       r_xr;
  logic [2*WIDTH-1:0]   r_yext;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;

  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_accNext;
  logic                 w_lastStep;

  assign w_addend   = r_yext << r_cnt;
  assign w_lastStep = (r_cnt == CW'(WIDTH - 1));

  // Booth pair {x[i], x[i-1]}: 01 adds, 10 subtracts the shifted multiplicand.
  always_comb begin
    w_accNext = r_acc;
    case (r_xr[1:0])
      2'b01:   w_accNext = r_acc + w_addend;
      2'b10:   w_accNext = r_acc - w_addend;
      default: w_accNext = r_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_xr    <= '0;
      r_yext  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Z       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        // DONE accepts a new start directly, giving back-to-back issue.
        IDLE, DONE: begin
          if (start) begin
            r_xr    <= {X, 1'b0};
            r_yext  <= {{WIDTH{Y[WIDTH-1]}}, Y};
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_acc <= w_accNext;
          r_xr  <= {r_xr[WIDTH], r_xr[WIDTH:1]};
          r_cnt <= r_cnt + 1'b1;
          if (w_lastStep) begin
            Z       <= w_accNext;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mul_ctrl.sv
// Bench for booth_seq_mul_ctrl: directed vectors feed an expected-product queue,
// and a monitor pops and compares it on every done pulse.
module tb_booth_seq_mul_ctrl;

  localparam int WIDTH = 16;
  localparam int CW    = 5;

  logic                clk;
  logic                rst;
  logic                start;
  logic [WIDTH-1:0]    X;
  logic [WIDTH-1:0]    Y;
  logic                busy;
  logic                done;
  logic [2*WIDTH-1:0]  Z;

  int checks   = 0;
  int failures = 0;
  int cycleCnt = 0;
  int doneCount = 0;
  int acceptEdge = 0;
  logic [2*WIDTH-1:0] modelZ = '0;
  logic [2*WIDTH-1:0] expQ[$];

  booth_seq_mul_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .Y     (Y),
    .busy  (busy),
    .done  (done),
    .Z     (Z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt = cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, actual, required, cycleCnt);
    end
  endtask

  // Monitor: every done cycle consumes one expected product; otherwise Z must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        doneCount++;
        checkOutput("busyInDone", 32'(busy), 32'd0);
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedDone actual Z=%h required no done", Z);
        end else begin
          modelZ = expQ.pop_front();
          checkOutput("product", Z, modelZ);
        end
      end else begin
        checkOutput("zStable", Z, modelZ);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    modelZ = '0;
    rst = 1'b0;
  endtask

  // Waits until the block can accept, queues the expected product, and clocks it in.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                               input logic [31:0] expected, input bit push, input bit holdStart);
    int n = 0;
    X = x;
    Y = y;
    start = 1'b1;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL acceptTimeout actual busy=1 required busy=0");
    end
    if (push) expQ.push_back(expected);
    tick();
    acceptEdge = cycleCnt;
    if (!holdStart) start = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    int n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL doneTimeout actual done=0 required done=1");
    end
    cyc = cycleCnt;
  endtask

  initial begin
    int busyCnt;
    int n;
    int t1;
    int t2;
    int dc;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic [15:0] corners [5];

    rst = 1'b1;
    start = 1'b0;
    X = '0;
    Y = '0;
    tick();
    applyReset();
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetZ", Z, 32'd0);

    // 3 * -5, measuring busy length and latency
    applyStimulus(16'd3, 16'hFFFB, 32'hFFFFFFF1, 1'b1, 1'b0);
    busyCnt = 0;
    n = 0;
    while (!done && n < 60) begin
      if (busy) busyCnt++;
      tick();
      n++;
    end
    checkOutput("busyCycles", 32'(busyCnt), 32'd16);
    checkOutput("latency", 32'(cycleCnt - acceptEdge + 1), 32'd17);
    checkOutput("zInDone", Z, 32'hFFFFFFF1);
    tick();
    checkOutput("donePulseWidth", 32'(done), 32'd0);

    // Signed extremes and zero
    applyStimulus(16'h8000, 16'h8000, 32'h40000000, 1'b1, 1'b0);
    waitDone(t1);
    applyStimulus(16'h7FFF, 16'h8000, 32'hC0008000, 1'b1, 1'b0);
    waitDone(t1);
    applyStimulus(16'd0, 16'd1234, 32'h00000000, 1'b1, 1'b0);
    waitDone(t1);
    tick();

    // Back-to-back with start held high
    applyStimulus(16'd7, 16'd6, 32'd42, 1'b1, 1'b1);
    waitDone(t1);
    X = 16'hFFFE;
    Y = 16'd9;
    expQ.push_back(32'hFFFFFFEE);
    tick();
    start = 1'b0;
    waitDone(t2);
    checkOutput("doneSpacing", 32'(t2 - t1), 32'd17);
    tick();

    // start pulse during CALC must be ignored
    dc = doneCount;
    applyStimulus(16'd100, 16'd200, 32'd20000, 1'b1, 1'b0);
    repeat (5) tick();
    X = 16'd1;
    Y = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    X = '0;
    Y = '0;
    waitDone(t1);
    repeat (25) tick();
    checkOutput("ignoredStartDones", 32'(doneCount - dc), 32'd1);

    // Reset in the middle of CALC aborts without a done
    dc = doneCount;
    applyStimulus(16'hFFFF, 16'hFFFF, 32'd0, 1'b0, 1'b0);
    repeat (8) tick();
    applyReset();
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortDone", 32'(done), 32'd0);
    checkOutput("abortZ", Z, 32'd0);
    repeat (30) tick();
    checkOutput("abortNoDone", 32'(doneCount - dc), 32'd0);
    applyStimulus(16'hFFFF, 16'hFFFF, 32'd1, 1'b1, 1'b0);
    waitDone(t1);
    tick();

    // Corner pairs then random operands, issued back-to-back
    corners[0] = 16'h8000;
    corners[1] = 16'h7FFF;
    corners[2] = 16'h0000;
    corners[3] = 16'hFFFF;
    corners[4] = 16'h0001;
    for (int i = 0; i < 25; i++) begin
      a = corners[i / 5];
      b = corners[i % 5];
      applyStimulus(a, b, 32'(a) * 32'(b), 1'b1, 1'b0);
    end
    for (int i = 0; i < 275; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      applyStimulus(a, b, 32'(a) * 32'(b), 1'b1, 1'b0);
    end
    waitDone(t1);
    repeat (5) tick();
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
